aes_avalon_interface: RTL and testbench

Avalon-MM slave register bank that sits directly upstream of the AES decryption core. Software writes a 128-bit key and ciphertext through 32-bit bus writes. A start/done handshake FSM drives the core's start input and captures the decrypted plaintext when the core reports completion. Software then polls a status register and reads back the plaintext.

---
 rtl/aes_avalon_interface.sv | 185 ++++++++++++++++++
 tb/tb_aes_avalon_interface.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_avalon_interface.sv
// aes_avalon_interface
// Avalon-MM slave register bank in front of the AES decryption core.
// Software loads key and ciphertext over 32-bit writes, starts the core via
// R14, polls R15 for completion and reads the captured plaintext from R8-R11.
//
// Bus handshake: there are no wait states. A write happens on any rising edge
// where AVL_CS & AVL_WRITE. A read happens where AVL_CS & AVL_READ & ~AVL_WRITE.
// Read data is registered. It is valid after that edge and holds until the
// next read. When read and write are asserted together, only the write is
// performed.
module aes_avalon_interface (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         AVL_CS,
  input  logic         AVL_READ,
  input  logic         AVL_WRITE,
  input  logic [3:0]   AVL_ADDR,
  input  logic [3:0]   AVL_BYTE_EN,
  input  logic [31:0]  AVL_WRITEDATA,
  output logic [31:0]  AVL_READDATA,
  output logic         AES_START,
  input  logic         AES_DONE,
  output logic [127:0] AES_KEY,
  output logic [127:0] AES_MSG_ENC,
  input  logic [127:0] AES_MSG_DEC,
  output logic [31:0]  EXPORT_DATA
);

  // IDLE: core not started; RUN: decrypting; FIN: result captured, core held
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // R0-R13 are plain storage; R14/R15 are single bits kept separately
  logic [31:0] r_regs [0:13];
  logic        r_start_bit;
  logic        r_done_bit;
  logic [31:0] r_readdata;

  logic        w_wr;
  logic        w_rd;
  logic        w_r14_wr;
  logic        w_key_lock;
  logic        w_capture;
  logic        w_done_set;
  logic        w_done_clr;
  logic [31:0] w_rd_mux;

  // Byte-lane merge of write data into an existing register value
  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] new_val,
                                          input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

  assign w_wr       = AVL_CS & AVL_WRITE;
  assign w_rd       = AVL_CS & AVL_READ & ~AVL_WRITE;
  // Only byte lane 0 carries the start bit
  assign w_r14_wr   = w_wr & (AVL_ADDR == 4'd14) & AVL_BYTE_EN[0];
  // Key and ciphertext must not change under the core while it decrypts
  assign w_key_lock = (r_state == S_RUN);

  // Next-state and control decode for the start/done handshake
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_done_set   = 1'b0;
    w_done_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_r14_wr && AVL_WRITEDATA[0]) begin
          w_next_state = S_RUN;
          w_done_clr   = 1'b1;
        end
      end
      S_RUN: begin
        // Abort takes priority over a coincident completion; plaintext and
        // done flag are left untouched on abort
        if (w_r14_wr && !AVL_WRITEDATA[0]) begin
          w_next_state = S_IDLE;
        end else if (AES_DONE) begin
          w_next_state = S_FIN;
          w_capture    = 1'b1;
          w_done_set   = 1'b1;
        end
      end
      S_FIN: begin
        // Software acknowledges the result by clearing the start bit
        if (w_r14_wr && !AVL_WRITEDATA[0]) begin
          w_next_state = S_IDLE;
          w_done_clr   = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Register file: bus writes to R0-R7 and R12-R13, capture into R8-R11
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 14; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (i >= 8 && i <= 11) begin
          if (w_capture) begin
            r_regs[i] <= AES_MSG_DEC[32*(11-i) +: 32];
          end
        end else if (w_wr && (AVL_ADDR == 4'(i)) && !(i < 8 && w_key_lock)) begin
          r_regs[i] <= f_merge(r_regs[i], AVL_WRITEDATA, AVL_BYTE_EN);
        end
      end
    end
  end

  // Start and done status bits
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_start_bit <= 1'b0;
      r_done_bit  <= 1'b0;
    end else begin
      if (w_r14_wr) begin
        r_start_bit <= AVL_WRITEDATA[0];
      end
      if (w_done_clr) begin
        r_done_bit <= 1'b0;
      end else if (w_done_set) begin
        r_done_bit <= 1'b1;
      end
    end
  end

  // Read multiplexer over the full 16-word map
  always_comb begin
    w_rd_mux = 32'd0;
    for (int i = 0; i < 14; i++) begin
      if (AVL_ADDR == 4'(i)) begin
        w_rd_mux = r_regs[i];
      end
    end
    if (AVL_ADDR == 4'd14) begin
      w_rd_mux = {31'd0, r_start_bit};
    end
    if (AVL_ADDR == 4'd15) begin
      w_rd_mux = {31'd0, r_done_bit};
    end
  end

  // Registered read data, updated only on a read strobe
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_readdata <= 32'd0;
    end else if (w_rd) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign AVL_READDATA = r_readdata;
  assign AES_START    = (r_state != S_IDLE);
  assign AES_KEY      = {r_regs[0], r_regs[1], r_regs[2], r_regs[3]};
  assign AES_MSG_ENC  = {r_regs[4], r_regs[5], r_regs[6], r_regs[7]};
  assign EXPORT_DATA  = {r_regs[0][31:16], r_regs[3][15:0]};

endmodule

// File: tb/tb_aes_avalon_interface.sv
// Directed testbench for aes_avalon_interface.
module tb_aes_avalon_interface;

  logic         clk;
  logic         reset_n;
  logic         avl_cs;
  logic         avl_read;
  logic         avl_write;
  logic [3:0]   avl_addr;
  logic [3:0]   avl_byte_en;
  logic [31:0]  avl_writedata;
  logic [31:0]  avl_readdata;
  logic         aes_start;
  logic         aes_done;
  logic [127:0] aes_key;
  logic [127:0] aes_msg_enc;
  logic [127:0] aes_msg_dec;
  logic [31:0]  export_data;

  int checks = 0;
  int errors = 0;

  aes_avalon_interface dut (
    .CLK           (clk),
    .RESET_N       (reset_n),
    .AVL_CS        (avl_cs),
    .AVL_READ      (avl_read),
    .AVL_WRITE     (avl_write),
    .AVL_ADDR      (avl_addr),
    .AVL_BYTE_EN   (avl_byte_en),
    .AVL_WRITEDATA (avl_writedata),
    .AVL_READDATA  (avl_readdata),
    .AES_START     (aes_start),
    .AES_DONE      (aes_done),
    .AES_KEY       (aes_key),
    .AES_MSG_ENC   (aes_msg_enc),
    .AES_MSG_DEC   (aes_msg_dec),
    .EXPORT_DATA   (export_data)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver: single-cycle write, inputs changed on the falling edge
  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    avl_cs        = 1'b1;
    avl_write     = 1'b1;
    avl_addr      = addr;
    avl_writedata = data;
    avl_byte_en   = be;
    @(negedge clk);
    avl_cs        = 1'b0;
    avl_write     = 1'b0;
    avl_byte_en   = 4'h0;
  endtask

  // Driver: single-cycle read, data sampled one falling edge later
  task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
    @(negedge clk);
    avl_cs   = 1'b1;
    avl_read = 1'b1;
    avl_addr = addr;
    @(negedge clk);
    avl_cs   = 1'b0;
    avl_read = 1'b0;
    data     = avl_readdata;
  endtask

  task automatic check_rd(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(tag, {96'd0, d}, {96'd0, exp});
  endtask

  // Core model: one-cycle completion pulse; plaintext stays driven
  task automatic done_pulse(input logic [127:0] pt);
    @(negedge clk);
    aes_msg_dec = pt;
    aes_done    = 1'b1;
    @(negedge clk);
    aes_done    = 1'b0;
  endtask

  localparam logic [127:0] KEY = 128'h00010203_04050607_08090A0B_0C0D0E0F;
  localparam logic [127:0] CT  = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
  localparam logic [127:0] PT1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] PT2 = 128'hFFEEDDCC_BBAA9988_77665544_33221100;
  localparam logic [127:0] JUNK = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;

  initial begin
    logic [127:0] key_v;
    logic [127:0] ct_v;
    key_v = KEY;
    ct_v  = CT;
    reset_n       = 1'b0;
    avl_cs        = 1'b0;
    avl_read      = 1'b0;
    avl_write     = 1'b0;
    avl_addr      = 4'h0;
    avl_byte_en   = 4'h0;
    avl_writedata = 32'h0;
    aes_done      = 1'b0;
    aes_msg_dec   = 128'h0;

    // Reset state
    #12;
    check("rst_start", {127'd0, aes_start}, 128'd0);
    check("rst_key", aes_key, 128'd0);
    check("rst_enc", aes_msg_enc, 128'd0);
    check("rst_export", {96'd0, export_data}, 128'd0);
    check("rst_rdata", {96'd0, avl_readdata}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Byte-enable write
    bus_write(4'd2, 32'hAABBCCDD, 4'b0101);
    check_rd("be_r2", 4'd2, 32'h00BB00DD);
    check("be_key", {96'd0, aes_key[63:32]}, {96'd0, 32'h00BB00DD});

    // Load key, ciphertext and scratch
    for (int i = 0; i < 4; i++) bus_write(4'(i), key_v[127-32*i -: 32], 4'hF);
    for (int i = 0; i < 4; i++) bus_write(4'(4+i), ct_v[127-32*i -: 32], 4'hF);
    bus_write(4'd12, 32'hDEADBEEF, 4'hF);
    check("key_out", aes_key, KEY);
    check("enc_out", aes_msg_enc, CT);
    check("export", {96'd0, export_data}, {96'd0, 32'h00010E0F});
    check_rd("r12_scratch", 4'd12, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    check("rdata_hold", {96'd0, avl_readdata}, {96'd0, 32'hDEADBEEF});

    // Read and write together: write wins, read data unchanged
    @(negedge clk);
    avl_cs = 1'b1; avl_read = 1'b1; avl_write = 1'b1;
    avl_addr = 4'd13; avl_writedata = 32'h13131313; avl_byte_en = 4'hF;
    @(negedge clk);
    avl_cs = 1'b0; avl_read = 1'b0; avl_write = 1'b0; avl_byte_en = 4'h0;
    check("rw_rdata", {96'd0, avl_readdata}, {96'd0, 32'hDEADBEEF});
    check_rd("rw_r13", 4'd13, 32'h13131313);

    // Start decrypt
    check("idle_start", {127'd0, aes_start}, 128'd0);
    bus_write(4'd14, 32'h1, 4'h1);
    check("run_start", {127'd0, aes_start}, 128'd1);
    check_rd("r14_set", 4'd14, 32'h1);
    check_rd("r15_run", 4'd15, 32'h0);
    bus_write(4'd5, 32'hFFFFFFFF, 4'hF);
    check_rd("r5_locked", 4'd5, 32'h6A7B0430);
    check("enc_locked", aes_msg_enc, CT);

    // Completion
    done_pulse(PT1);
    check_rd("r15_fin", 4'd15, 32'h1);
    check_rd("r8_pt1", 4'd8, 32'h00112233);
    check_rd("r9_pt1", 4'd9, 32'h44556677);
    check_rd("r10_pt1", 4'd10, 32'h8899AABB);
    check_rd("r11_pt1", 4'd11, 32'hCCDDEEFF);
    check("fin_start", {127'd0, aes_start}, 128'd1);
    bus_write(4'd9, 32'h12345678, 4'hF);
    check_rd("r9_ro", 4'd9, 32'h44556677);
    bus_write(4'd14, 32'h1, 4'h1);
    check("fin_ign1", {127'd0, aes_start}, 128'd1);
    check_rd("fin_r15_keep", 4'd15, 32'h1);

    // Acknowledge
    bus_write(4'd14, 32'h0, 4'h1);
    check("ack_start", {127'd0, aes_start}, 128'd0);
    check_rd("ack_r15", 4'd15, 32'h0);
    bus_write(4'd15, 32'h1, 4'hF);
    check_rd("r15_ro", 4'd15, 32'h0);

    // Abort
    bus_write(4'd14, 32'h1, 4'h1);
    check("abort_run", {127'd0, aes_start}, 128'd1);
    bus_write(4'd14, 32'h0, 4'h1);
    check("abort_start", {127'd0, aes_start}, 128'd0);
    check_rd("abort_r15", 4'd15, 32'h0);
    check_rd("abort_r8", 4'd8, 32'h00112233);
    check_rd("abort_r11", 4'd11, 32'hCCDDEEFF);
    done_pulse(JUNK);
    check("idle_done_ign", {127'd0, aes_start}, 128'd0);
    check_rd("idle_r8", 4'd8, 32'h00112233);
    check_rd("idle_r15", 4'd15, 32'h0);

    // Restart and second capture
    bus_write(4'd14, 32'h1, 4'h1);
    check("restart", {127'd0, aes_start}, 128'd1);
    done_pulse(PT2);
    check_rd("r15_pt2", 4'd15, 32'h1);
    check_rd("r8_pt2", 4'd8, 32'hFFEEDDCC);
    check_rd("r9_pt2", 4'd9, 32'hBBAA9988);
    check_rd("r10_pt2", 4'd10, 32'h77665544);
    check_rd("r11_pt2", 4'd11, 32'h33221100);
    bus_write(4'd14, 32'h0, 4'h1);

    // Reset mid-RUN with nonzero registers and read data
    bus_write(4'd14, 32'h1, 4'h1);
    check("pre_rst_run", {127'd0, aes_start}, 128'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_start", {127'd0, aes_start}, 128'd0);
    check("mid_rst_key", aes_key, 128'd0);
    check("mid_rst_enc", aes_msg_enc, 128'd0);
    check("mid_rst_export", {96'd0, export_data}, 128'd0);
    check("mid_rst_rdata", {96'd0, avl_readdata}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) check_rd($sformatf("post_rst_r%0d", i), 4'(i), 32'h0);
    check("post_rst_start", {127'd0, aes_start}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
